// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the stack-pointer operation encoding
// used by the register file and its SP counter.
package cpu_pkg;

  localparam int CPU_WIDTH = 18;
  localparam int CPU_REGS  = 8;
  localparam int CPU_SP_INDEX = CPU_REGS - 1;

  typedef enum logic [1:0] {
    SP_HOLD = 2'd0,
    SP_LOAD = 2'd1,
    SP_INC  = 2'd2,
    SP_DEC  = 2'd3
  } sp_op_e;

  // A port write to the SP wins; inc and dec together cancel out.
  function automatic sp_op_e sp_resolve(input logic load, input logic inc, input logic dec);
    if (load)
      return SP_LOAD;
    if (inc && !dec)
      return SP_INC;
    if (dec && !inc)
      return SP_DEC;
    return SP_HOLD;
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sp_counter.sv
// Stack-pointer register: loadable, increments/decrements modulo 2^WIDTH,
// asynchronous reset to SP_RESET.
module sp_counter
  import cpu_pkg::*;
#(
  parameter int              WIDTH    = CPU_WIDTH,
  parameter logic [WIDTH-1:0] SP_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] value
);

  sp_op_e op;

  assign op = sp_resolve(load, inc, dec);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= SP_RESET;
    end else begin
      unique case (op)
        SP_LOAD: value <= load_data;
        SP_INC:  value <= value + WIDTH'(1);
        SP_DEC:  value <= value - WIDTH'(1);
        default: value <= value;
      endcase
    end
  end

endmodule

// File: rtl/register_file.sv
// DEPTH-entry register file: one synchronous write port, two combinational
// read ports with optional bypass, optional zero register, built-in SP.
module register_file
  import cpu_pkg::*;
#(
  parameter int               WIDTH       = CPU_WIDTH,
  parameter int               DEPTH       = CPU_REGS,
  parameter bit               BYPASS      = 1'b1,
  parameter bit               ZERO_REG    = 1'b0,
  parameter int               SP_INDEX    = DEPTH - 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] SP_RESET    = '0,
  localparam int              ADDR_W      = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic              sp_inc,
  input  logic              sp_dec,
  output logic [WIDTH-1:0]  sp_value
);

  // Every encodable address gets a slot; slots at or above DEPTH read as 0,
  // so the read mux needs no range compare.
  localparam int SLOTS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] SP_ADDR = ADDR_W'(SP_INDEX);

  if ((ZERO_REG && SP_INDEX == 0) || SP_INDEX < 0 || SP_INDEX >= DEPTH) begin : g_illegal_sp
    $error("register_file: illegal SP_INDEX %0d for DEPTH %0d / ZERO_REG %0d",
           SP_INDEX, DEPTH, ZERO_REG);
  end
  if (DEPTH < 2 || DEPTH > 32) begin : g_illegal_depth
    $error("register_file: DEPTH %0d outside 2..32", DEPTH);
  end

  logic [WIDTH-1:0] reg_q    [SLOTS];
  logic             writable [SLOTS];
  logic [WIDTH-1:0] sp_q;
  logic             sp_load;
  logic             hit_a;
  logic             hit_b;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    if (i >= DEPTH) begin : g_empty
      assign reg_q[i]    = '0;
      assign writable[i] = 1'b0;
    end else if (ZERO_REG && i == 0) begin : g_zero
      assign reg_q[i]    = '0;
      assign writable[i] = 1'b0;
    end else if (i == SP_INDEX) begin : g_sp
      assign reg_q[i]    = sp_q;
      assign writable[i] = 1'b1;
    end else begin : g_gen
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);
      logic [WIDTH-1:0] q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          q <= RESET_VALUE;
        else if (we && waddr == IDX)
          q <= wdata;
      end
      assign reg_q[i]    = q;
      assign writable[i] = 1'b1;
    end
  end

  assign sp_load = we && (waddr == SP_ADDR);

  sp_counter #(
    .WIDTH    (WIDTH),
    .SP_RESET (SP_RESET)
  ) u_sp (
    .clk       (clk),
    .reset     (reset),
    .load      (sp_load),
    .load_data (wdata),
    .inc       (sp_inc),
    .dec       (sp_dec),
    .value     (sp_q)
  );

  // Forward only writes that will actually land; inc/dec never forward.
  assign hit_a = BYPASS && we && !reset && (waddr == raddr_a) && writable[waddr];
  assign hit_b = BYPASS && we && !reset && (waddr == raddr_b) && writable[waddr];

  assign rdata_a  = hit_a ? wdata : reg_q[raddr_a];
  assign rdata_b  = hit_b ? wdata : reg_q[raddr_b];
  assign sp_value = sp_q;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a default instance (bypass, SP at r7) and
// a DEPTH=6 instance (no bypass, zero register, SP at r5, non-zero resets).
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [2:0]  waddr;
  logic [17:0] wdata;
  logic [2:0]  raddr_a;
  logic [2:0]  raddr_b;
  logic        sp_inc;
  logic        sp_dec;
  logic [17:0] x_rdata_a, x_rdata_b, x_sp;
  logic [17:0] y_rdata_a, y_rdata_b, y_sp;

  int n_cmp = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of run");
    $fatal(1, "watchdog expired");
  end

  // ---------------- DUTs ----------------
  register_file dut_x (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr_a  (raddr_a),
    .rdata_a  (x_rdata_a),
    .raddr_b  (raddr_b),
    .rdata_b  (x_rdata_b),
    .sp_inc   (sp_inc),
    .sp_dec   (sp_dec),
    .sp_value (x_sp)
  );

  register_file #(
    .WIDTH       (18),
    .DEPTH       (6),
    .BYPASS      (1'b0),
    .ZERO_REG    (1'b1),
    .SP_INDEX    (5),
    .RESET_VALUE (18'h00007),
    .SP_RESET    (18'h00040)
  ) dut_y (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr_a  (raddr_a),
    .rdata_a  (y_rdata_a),
    .raddr_b  (raddr_b),
    .rdata_b  (y_rdata_b),
    .sp_inc   (sp_inc),
    .sp_dec   (sp_dec),
    .sp_value (y_sp)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%05h, expected 0x%05h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus + scoreboard ----------------
  logic [17:0] y_regs [6];
  logic        inc_v [3];
  logic        dec_v [3];
  logic [17:0] y_sp_exp [3];

  initial begin
    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    raddr_a = 3'd2; raddr_b = 3'd0; sp_inc = 1'b0; sp_dec = 1'b0;
    #12;
    check("rst_x_a", x_rdata_a, 18'h00000);
    check("rst_y_a", y_rdata_a, 18'h00007);
    check("rst_x_sp", x_sp, 18'h00000);
    check("rst_y_sp", y_sp, 18'h00040);
    reset = 1'b0;

    // First edge after release accepts the write; then async reset mid-cycle.
    we = 1'b1; waddr = 3'd2; wdata = 18'h1ABCD;
    step();
    we = 1'b0; #1;
    check("wr_r2_x", x_rdata_a, 18'h1ABCD);
    check("wr_r2_y", y_rdata_a, 18'h1ABCD);
    #1 reset = 1'b1;
    #1;
    check("async_rst_x_a", x_rdata_a, 18'h00000);
    check("async_rst_y_a", y_rdata_a, 18'h00007);
    check("async_rst_x_sp", x_sp, 18'h00000);
    check("async_rst_y_sp", y_sp, 18'h00040);
    reset = 1'b0;
    step();

    // r3 on both ports: bypass on x, old value on y until the edge.
    we = 1'b1; waddr = 3'd3; wdata = 18'h2F0F0; raddr_a = 3'd3; raddr_b = 3'd3;
    #1;
    check("byp_r3_x_a", x_rdata_a, 18'h2F0F0);
    check("byp_r3_x_b", x_rdata_b, 18'h2F0F0);
    check("nobyp_r3_y_a", y_rdata_a, 18'h00007);
    step();
    we = 1'b0; #1;
    check("r3_x_a", x_rdata_a, 18'h2F0F0);
    check("r3_x_b", x_rdata_b, 18'h2F0F0);
    check("r3_y_a", y_rdata_a, 18'h2F0F0);
    check("r3_y_b", y_rdata_b, 18'h2F0F0);

    // r5: general on x, SP on y.
    we = 1'b1; waddr = 3'd5; wdata = 18'h00001; raddr_a = 3'd5;
    #1;
    check("byp_r5_x", x_rdata_a, 18'h00001);
    check("nobyp_r5_y", y_rdata_a, 18'h00040);
    step();
    we = 1'b0; #1;
    check("r5_x", x_rdata_a, 18'h00001);
    check("r5_y", y_rdata_a, 18'h00001);
    check("r5_y_sp", y_sp, 18'h00001);
    check("r5_x_sp", x_sp, 18'h00000);

    // r0: ordinary on x, hardwired zero on y.
    we = 1'b1; waddr = 3'd0; wdata = 18'h3FFFF; raddr_a = 3'd0;
    #1;
    check("byp_r0_x", x_rdata_a, 18'h3FFFF);
    check("zero_r0_y_same", y_rdata_a, 18'h00000);
    step();
    we = 1'b0; #1;
    check("r0_x", x_rdata_a, 18'h3FFFF);
    check("zero_r0_y", y_rdata_a, 18'h00000);

    // waddr 7: SP on x, out of range on y.
    we = 1'b1; waddr = 3'd7; wdata = 18'h15555; raddr_a = 3'd7; raddr_b = 3'd3;
    #1;
    check("byp_sp_x", x_rdata_a, 18'h15555);
    check("oor_rd_y_a", y_rdata_a, 18'h00000);
    check("oor_rd_y_b", y_rdata_b, 18'h2F0F0);
    step();
    we = 1'b0; #1;
    check("sp_wr_x", x_sp, 18'h15555);
    check("oor_y_sp", y_sp, 18'h00001);
    check("oor_rd7_y", y_rdata_a, 18'h00000);
    y_regs[0] = 18'h00000; y_regs[1] = 18'h00007; y_regs[2] = 18'h00007;
    y_regs[3] = 18'h2F0F0; y_regs[4] = 18'h00007; y_regs[5] = 18'h00001;
    for (int i = 0; i < 6; i++) begin
      raddr_a = 3'(i); #1;
      check($sformatf("oor_keep_y_r%0d", i), y_rdata_a, y_regs[i]);
    end
    raddr_a = 3'd6; #1;
    check("oor_rd6_y", y_rdata_a, 18'h00000);
    check("r6_x", x_rdata_a, 18'h00000);

    // SP wrap sequence on x; y counts in step from 1.
    we = 1'b1; waddr = 3'd7; wdata = 18'h3FFFF;
    step();
    we = 1'b0; raddr_a = 3'd7; sp_inc = 1'b1; #1;
    check("inc_no_byp_x", x_rdata_a, 18'h3FFFF);
    check("sp_pre_x", x_sp, 18'h3FFFF);
    inc_v[0] = 1'b1; dec_v[0] = 1'b0; exp_q.push_back(18'h00000); y_sp_exp[0] = 18'h00002;
    inc_v[1] = 1'b0; dec_v[1] = 1'b1; exp_q.push_back(18'h3FFFF); y_sp_exp[1] = 18'h00001;
    inc_v[2] = 1'b1; dec_v[2] = 1'b1; exp_q.push_back(18'h3FFFF); y_sp_exp[2] = 18'h00001;
    for (int i = 0; i < 3; i++) begin
      logic [17:0] e;
      sp_inc = inc_v[i]; sp_dec = dec_v[i];
      step();
      e = exp_q.pop_front();
      check($sformatf("sp_seq%0d_x", i), x_sp, e);
      check($sformatf("sp_seq%0d_x_port", i), x_rdata_a, e);
      check($sformatf("sp_seq%0d_y", i), y_sp, y_sp_exp[i]);
    end
    sp_inc = 1'b0; sp_dec = 1'b0;

    // Write to SP beats a simultaneous increment.
    we = 1'b1; waddr = 3'd7; wdata = 18'h00100; sp_inc = 1'b1;
    step();
    we = 1'b0; sp_inc = 1'b0; #1;
    check("sp_prio_x", x_sp, 18'h00100);
    check("sp_prio_y_inc", y_sp, 18'h00002);

    // Count from 0x10, reset pulse before the third edge.
    we = 1'b1; waddr = 3'd7; wdata = 18'h00010;
    step();
    waddr = 3'd5;
    step();
    we = 1'b0; sp_inc = 1'b1;
    step();
    check("cnt1_x", x_sp, 18'h00011);
    check("cnt1_y", y_sp, 18'h00011);
    step();
    check("cnt2_x", x_sp, 18'h00012);
    check("cnt2_y", y_sp, 18'h00012);
    #2 reset = 1'b1;
    #1;
    check("cnt_rst_x", x_sp, 18'h00000);
    check("cnt_rst_y", y_sp, 18'h00040);
    reset = 1'b0;
    step();
    check("cnt_resume_x", x_sp, 18'h00001);
    check("cnt_resume_y", y_sp, 18'h00041);
    sp_inc = 1'b0;

    // Writes held across an edge while reset is high are dropped.
    reset = 1'b1; we = 1'b1; waddr = 3'd3; wdata = 18'h00003; raddr_a = 3'd3;
    #1;
    check("rst_no_byp_x", x_rdata_a, 18'h00000);
    step();
    check("rst_wr_x", x_rdata_a, 18'h00000);
    check("rst_wr_y", y_rdata_a, 18'h00007);
    reset = 1'b0; we = 1'b0; #1;
    check("rst_wr_after_x", x_rdata_a, 18'h00000);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
Parametrised multi-register storage block, successor to the single 8-bit load register. Default width is 18 bits to match the CPU datapath.
- DEPTH registers, one synchronous write port, two combinational read ports.
- Optional write-to-read bypass and optional hardwired zero register.
- One register doubles as a stack pointer with dedicated increment/decrement controls.
- Sits between decode and ALU in the CPU datapath.

Parameters:
WIDTH, 18, data width of every register
DEPTH, 8, number of registers (2..32, need not be a power of two)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes
SP_INDEX, DEPTH-1, index of the stack-pointer register
RESET_VALUE, 0, reset value of all general registers
SP_RESET, 0, reset value of the SP register
(localparam ADDR_W = $clog2(DEPTH), minimum 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
we  input  1  write enable
waddr  input  ADDR_W  write register index
wdata  input  WIDTH  write data
raddr_a  input  ADDR_W  read port A index
rdata_a  output  WIDTH  read port A data
raddr_b  input  ADDR_W  read port B index
rdata_b  output  WIDTH  read port B data
sp_inc  input  1  increment SP by 1 at next edge
sp_dec  input  1  decrement SP by 1 at next edge
sp_value  output  WIDTH  current SP register contents, registered, no bypass

Behaviour:
Reset:
- Asserting reset immediately clears all registers to RESET_VALUE and SP to SP_RESET, independent of clk.
- While reset is high, all writes and SP operations are ignored.
- Outputs after reset: rdata_a/b show reset contents of the addressed register; sp_value = SP_RESET.
- Deassertion is sampled at the next rising edge; the first write is accepted on the first edge with reset low.

Write:
- On rising edge with we=1 and waddr < DEPTH, reg[waddr] <= wdata.
- waddr >= DEPTH: write ignored.
- ZERO_REG=1 and waddr=0: write ignored.

Read:
- Combinational, zero latency.
- raddr >= DEPTH reads 0.
- ZERO_REG=1 with raddr=0 reads 0.
- BYPASS=1 and we=1 and waddr==raddr and the address is writable: rdata = wdata in the same cycle.
- BYPASS=0: read returns the old contents until after the edge.
- Both ports are independent and may address the same register.

SP operations, resolved per edge:
- Write to SP_INDEX has priority: SP <= wdata, and inc/dec are ignored.
- Otherwise sp_inc=1, sp_dec=0: SP <= SP+1.
- Otherwise sp_dec=1, sp_inc=0: SP <= SP-1.
- sp_inc=sp_dec=1: SP unchanged.
- Arithmetic is modulo 2^WIDTH: 0x3FFFF+1 = 0x00000, and 0x00000-1 = 0x3FFFF.
- Results of inc/dec are visible on sp_value and read ports one cycle later; bypass never applies to inc/dec.
- SP_INDEX is a normal read/write address for the ports.

Illegal configuration:
- ZERO_REG=1 with SP_INDEX=0, or SP_INDEX >= DEPTH.
- Flagged by an elaboration-time $error in simulation; synthesis behaviour is undefined.

No other state; no handshake; no stall.

Decomposition:
Shared package cpu_pkg:
- CPU_WIDTH = 18
- default register count
- register index constants (SP index)
Sub-module sp_counter:
- One WIDTH-bit register with async reset to SP_RESET.
- Inputs: load, load_data, inc, dec.
- Implements the priority and wrap rules.
General registers are an array in register_file; read muxes and bypass logic stay in the top module.

Test Plan:
- Reset: assert reset mid-cycle after writing r2=0x1ABCD -> rdata_a(r2)=0x00000 immediately, before any clk edge; sp_value=SP_RESET.
- Write/read: write r3=0x2F0F0, then read A=r3, B=r3 -> both 0x2F0F0 the cycle after the edge. Write r5=0x00001 with raddr_a=5, BYPASS=1 -> rdata_a=0x00001 in the same cycle. Same case with BYPASS=0 -> old value in the same cycle, 0x00001 after the edge.
- Zero register: ZERO_REG=1, write r0=0x3FFFF -> r0 reads 0x00000. Out-of-range: DEPTH=6, write waddr=7 -> no register changes; raddr=7 reads 0.
- SP wrap: SP=0x3FFFF, sp_inc one edge -> sp_value=0x00000. Then sp_dec -> 0x3FFFF. sp_inc=sp_dec=1 -> unchanged.
- SP priority: we=1, waddr=SP_INDEX, wdata=0x00100, with sp_inc=1 -> sp_value=0x00100, not 0x00101.
- Reset mid-operation: sp_inc held high for 3 edges from SP=0x00010, reset pulsed before the third edge -> sp_value=SP_RESET. Counting resumes from SP_RESET on the first edge after reset is released.
